// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, the strobe bundle driven to the pipeline registers, and ID/EX control-bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } state_e;

  // Default register-specifier width.
  localparam int REG_W_DEF = 4;

  // Positions of the load and register-write flags inside the 7-bit ID/EX control field.
  localparam int IDEX_MEMREAD_BIT  = 3;
  localparam int IDEX_REGWRITE_BIT = 6;

  typedef struct packed {
    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_bubble;
    logic exmem_wen;
    logic memwb_wen;
  } strobes_t;

  localparam strobes_t STRB_RUN  = 7'b1101011;
  localparam strobes_t STRB_HOLD = 7'b0000000;

  function automatic logic idex_is_load(input logic [6:0] ctrl);
    return ctrl[IDEX_MEMREAD_BIT] & ctrl[IDEX_REGWRITE_BIT];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of decoded-ID, EX, memory-handshake inputs and pipeline-register strobes
// exchanged between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_pkg::REG_W_DEF,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_dst;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ack;

  logic             pc_wen;
  logic             ifid_wen;
  logic             ifid_flush;
  logic             idex_wen;
  logic             idex_bubble;
  logic             exmem_wen;
  logic             memwb_wen;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    output ex_memread, ex_regwrite, ex_dst, br_taken, mem_req, mem_ack,
    input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble,
    input  exmem_wen, memwb_wen, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    input  ex_memread, ex_regwrite, ex_dst, br_taken, mem_req, mem_ack,
    output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble,
    output exmem_wen, memwb_wen, halted, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hz_detect.sv
// Combinational load-use hazard comparator: the instruction in ID reads a register
// that the load currently in EX has not yet produced.
module hz_detect #(
  parameter int REG_W = pipe_pkg::REG_W_DEF
) (
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_uses_rs,
  input  logic             i_uses_rt,
  input  logic             i_ex_memread,
  input  logic             i_ex_regwrite,
  input  logic [REG_W-1:0] i_ex_dst,
  output logic             o_lu_haz
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_ex_load;

  assign w_rs_hit  = i_uses_rs & (i_id_rs == i_ex_dst);
  assign w_rt_hit  = i_uses_rt & (i_id_rt == i_ex_dst);
  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_ex_load = i_ex_memread & i_ex_regwrite & (i_ex_dst != '0);
  assign o_lu_haz  = i_id_valid & w_ex_load & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stalls on load-use, kills wrong-path fetches on taken branches,
// freezes the pipe during data-memory waits and drains it to a sticky halt on HLT.
module pipe_hazard_ctrl #(
  parameter int REG_W     = pipe_pkg::REG_W_DEF,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_pkg::*;

  localparam int DCW = $clog2(DRAIN_CYC + 1);

  state_e           r_state;
  state_e           w_next;
  state_e           w_eff;
  logic             r_ret_drain;
  logic             w_ret_next;
  logic [DCW-1:0]   r_drain_cnt;
  logic [DCW-1:0]   w_cnt_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall;
  strobes_t         w_strb;
  logic             w_lu_haz;
  logic             w_memhold;
  logic             w_stall_inc;

  hz_detect #(.REG_W(REG_W)) u_hz (
    .i_id_valid   (bus.id_valid),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_uses_rs    (bus.id_uses_rs),
    .i_uses_rt    (bus.id_uses_rt),
    .i_ex_memread (bus.ex_memread),
    .i_ex_regwrite(bus.ex_regwrite),
    .i_ex_dst     (bus.ex_dst),
    .o_lu_haz     (w_lu_haz)
  );

  assign w_memhold = bus.mem_req & ~bus.mem_ack;

  always_comb begin
    // On the completing cycle of a memory wait, behave exactly as the state we came from.
    w_eff = r_state;
    if (r_state == MEM_WAIT && bus.mem_req && bus.mem_ack)
      w_eff = r_ret_drain ? DRAIN : RUN;

    w_strb     = STRB_RUN;
    w_next     = w_eff;
    w_ret_next = r_ret_drain;
    w_cnt_next = r_drain_cnt;

    case (w_eff)
      RUN: begin
        if (w_memhold) begin
          w_strb     = STRB_HOLD;
          w_next     = MEM_WAIT;
          w_ret_next = 1'b0;
        end else if (bus.br_taken) begin
          w_strb.ifid_flush  = 1'b1;
          w_strb.idex_bubble = 1'b1;
        end else if (w_lu_haz) begin
          w_strb.pc_wen      = 1'b0;
          w_strb.ifid_wen    = 1'b0;
          w_strb.idex_bubble = 1'b1;
        end else if (bus.id_halt && bus.id_valid) begin
          w_strb.pc_wen     = 1'b0;
          w_strb.ifid_flush = 1'b1;
          w_next            = DRAIN;
          w_cnt_next        = DCW'(DRAIN_CYC);
        end
      end
      DRAIN: begin
        if (w_memhold) begin
          w_strb     = STRB_HOLD;
          w_next     = MEM_WAIT;
          w_ret_next = 1'b1;
        end else if (bus.br_taken) begin
          // The HLT being drained was fetched down the wrong path; resume normal flow.
          w_strb.ifid_flush  = 1'b1;
          w_strb.idex_bubble = 1'b1;
          w_next             = RUN;
          w_cnt_next         = '0;
        end else begin
          w_strb.pc_wen     = 1'b0;
          w_strb.ifid_flush = 1'b1;
          w_cnt_next        = r_drain_cnt - 1'b1;
          if (r_drain_cnt == DCW'(1))
            w_next = HALT;
        end
      end
      default: w_strb = STRB_HOLD;
    endcase
  end

  assign w_stall_inc = ~w_strb.pc_wen & (r_state != HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_ret_drain <= 1'b0;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
      r_stall     <= '0;
    end else begin
      r_state     <= w_next;
      r_ret_drain <= w_ret_next;
      r_drain_cnt <= w_cnt_next;
      r_halted    <= (w_next == HALT);
      if (w_stall_inc && r_stall != {CNT_W{1'b1}})
        r_stall <= r_stall + 1'b1;
    end
  end

  assign bus.pc_wen      = w_strb.pc_wen;
  assign bus.ifid_wen    = w_strb.ifid_wen;
  assign bus.ifid_flush  = w_strb.ifid_flush;
  assign bus.idex_wen    = w_strb.idex_wen;
  assign bus.idex_bubble = w_strb.idex_bubble;
  assign bus.exmem_wen   = w_strb.exmem_wen;
  assign bus.memwb_wen   = w_strb.memwb_wen;
  assign bus.halted      = r_halted;
  assign bus.stall_cnt   = r_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table in RUN plus
// hand-written memory-wait, drain, cancel, reset and saturation sequences.
module tb_pipe_hazard_ctrl;

  // Strobe order: pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb
  localparam logic [6:0] IDLE = 7'b1101011;
  localparam logic [6:0] LU   = 7'b0001111;
  localparam logic [6:0] BR   = 7'b1111111;
  localparam logic [6:0] DRN  = 7'b0111011;
  localparam logic [6:0] HOLD = 7'b0000000;

  typedef struct {
    string      nm;
    logic       idv;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic       halt;
    logic       mr;
    logic       rw;
    logic [3:0] dst;
    logic       br;
    logic       mreq;
    logic       mack;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  int   exp_stall = 0;
  vec_t vt[14];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(2))  bus2 ();

  pipe_hazard_ctrl #(.REG_W(4), .CNT_W(16), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pipe_hazard_ctrl #(.REG_W(4), .CNT_W(2), .DRAIN_CYC(3)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_rs       = bus.id_rs;
  assign bus2.id_rt       = bus.id_rt;
  assign bus2.id_uses_rs  = bus.id_uses_rs;
  assign bus2.id_uses_rt  = bus.id_uses_rt;
  assign bus2.id_halt     = bus.id_halt;
  assign bus2.ex_memread  = bus.ex_memread;
  assign bus2.ex_regwrite = bus.ex_regwrite;
  assign bus2.ex_dst      = bus.ex_dst;
  assign bus2.br_taken    = bus.br_taken;
  assign bus2.mem_req     = bus.mem_req;
  assign bus2.mem_ack     = bus.mem_ack;

  function automatic vec_t mk(input string nm, input logic idv, input logic [3:0] rs,
                              input logic [3:0] rt, input logic urs, input logic urt,
                              input logic halt, input logic mr, input logic rw,
                              input logic [3:0] dst, input logic br, input logic mreq,
                              input logic mack, input logic [6:0] exp);
    vec_t v;
    v.nm = nm; v.idv = idv; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.halt = halt; v.mr = mr; v.rw = rw; v.dst = dst; v.br = br;
    v.mreq = mreq; v.mack = mack; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {bus.pc_wen, bus.ifid_wen, bus.ifid_flush, bus.idex_wen,
            bus.idex_bubble, bus.exmem_wen, bus.memwb_wen};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.id_valid = v.idv;  bus.id_rs = v.rs;  bus.id_rt = v.rt;
    bus.id_uses_rs = v.urs; bus.id_uses_rt = v.urt; bus.id_halt = v.halt;
    bus.ex_memread = v.mr; bus.ex_regwrite = v.rw; bus.ex_dst = v.dst;
    bus.br_taken = v.br;   bus.mem_req = v.mreq; bus.mem_ack = v.mack;
  endtask

  task automatic idle();
    apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
  endtask

  // Check combinational strobes and registered status, then advance one clock.
  task automatic cyc(input string nm, input logic [6:0] eo, input logic eh);
    #2;
    chk({nm, ".strobes"}, 32'(outs()), 32'(eo));
    chk({nm, ".halted"}, 32'(bus.halted), 32'(eh));
    chk({nm, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall));
    @(posedge clk); #1;
    if (!eo[6] && !eh) exp_stall++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_stall = 0;
  endtask

  task automatic halt_issue(input string nm);
    idle();
    bus.id_halt = 1'b1;
    bus.id_valid = 1'b1;
    cyc(nm, DRN, 1'b0);
    idle();
  endtask

  initial begin
    vt[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    vt[1]  = mk("lu_rs",       1, 3, 0, 1, 0, 0, 1, 1, 3, 0, 0, 0, LU);
    vt[2]  = mk("lu_rt",       1, 1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, LU);
    vt[3]  = mk("dst_zero",    1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, IDLE);
    vt[4]  = mk("rs_unused",   1, 3, 0, 0, 1, 0, 1, 1, 3, 0, 0, 0, IDLE);
    vt[5]  = mk("no_memread",  1, 3, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0, IDLE);
    vt[6]  = mk("no_regwrite", 1, 3, 0, 1, 0, 0, 1, 0, 3, 0, 0, 0, IDLE);
    vt[7]  = mk("id_invalid",  0, 3, 0, 1, 0, 0, 1, 1, 3, 0, 0, 0, IDLE);
    vt[8]  = mk("rs_mismatch", 1, 4, 0, 1, 0, 0, 1, 1, 3, 0, 0, 0, IDLE);
    vt[9]  = mk("br_over_lu",  1, 3, 0, 1, 0, 0, 1, 1, 3, 1, 0, 0, BR);
    vt[10] = mk("br_only",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR);
    vt[11] = mk("req_ack_lu",  1, 3, 0, 1, 0, 0, 1, 1, 3, 0, 1, 1, LU);
    vt[12] = mk("ack_no_req",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
    vt[13] = mk("halt_inval",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, IDLE);

    idle();
    #1;
    chk("reset.strobes", 32'(outs()), 32'(IDLE));
    chk("reset.halted", 32'(bus.halted), 32'd0);
    chk("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vt[i]) begin
      apply(vt[i]);
      cyc(vt[i].nm, vt[i].exp, 1'b0);
    end

    // Multi-cycle memory wait: held four cycles, released on ack.
    idle();
    bus.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc("mw_hold", HOLD, 1'b0);
    bus.mem_ack = 1'b1;
    cyc("mw_ack", IDLE, 1'b0);
    idle();
    cyc("mw_after", IDLE, 1'b0);

    // Memory hold outranks a taken branch.
    bus.mem_req = 1'b1;
    bus.br_taken = 1'b1;
    cyc("hold_over_br", HOLD, 1'b0);
    bus.br_taken = 1'b0;
    bus.mem_ack = 1'b1;
    cyc("ack_run", IDLE, 1'b0);
    idle();

    // HLT drains for three cycles, then halts and ignores everything.
    halt_issue("halt_issue");
    for (int i = 0; i < 3; i++) cyc("drain", DRN, 1'b0);
    cyc("halted", HOLD, 1'b1);
    bus.br_taken = 1'b1;
    bus.mem_req = 1'b1;
    cyc("halt_ign_br_mem", HOLD, 1'b1);
    bus.br_taken = 1'b0;
    bus.mem_ack = 1'b1;
    cyc("halt_ign_ack", HOLD, 1'b1);
    idle();
    do_reset();

    // Taken branch on the second drain cycle cancels the halt.
    halt_issue("cancel_issue");
    cyc("cancel_d1", DRN, 1'b0);
    bus.br_taken = 1'b1;
    cyc("cancel_br", BR, 1'b0);
    idle();
    cyc("cancel_run", IDLE, 1'b0);
    cyc("cancel_run2", IDLE, 1'b0);

    // A memory hold during drain freezes the drain countdown.
    halt_issue("frz_issue");
    cyc("frz_d1", DRN, 1'b0);
    bus.mem_req = 1'b1;
    cyc("frz_hold", HOLD, 1'b0);
    bus.mem_ack = 1'b1;
    cyc("frz_ack", DRN, 1'b0);
    idle();
    cyc("frz_d3", DRN, 1'b0);
    cyc("frz_halt", HOLD, 1'b1);
    do_reset();

    // Asynchronous reset while waiting on memory with seven stalls recorded.
    bus.mem_req = 1'b1;
    for (int i = 0; i < 7; i++) cyc("rst_hold", HOLD, 1'b0);
    idle();
    #1;
    chk("rst_pre.strobes", 32'(outs()), 32'(HOLD));
    chk("rst_pre.stall_cnt", 32'(bus.stall_cnt), 32'd7);
    rst = 1'b0;
    #1;
    chk("rst_async.strobes", 32'(outs()), 32'(IDLE));
    chk("rst_async.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_async.halted", 32'(bus.halted), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_stall = 0;
    cyc("post_rst", IDLE, 1'b0);

    // Five load-use stalls saturate the 2-bit counter at 3.
    apply(vt[1]);
    for (int i = 0; i < 5; i++) begin
      cyc("sat_lu", LU, 1'b0);
      chk("sat_cnt", 32'(bus2.stall_cnt), 32'((exp_stall > 3) ? 3 : exp_stall));
    end
    idle();
    #2;
    chk("sat_final_wide", 32'(bus.stall_cnt), 32'd5);
    chk("sat_final_narrow", 32'(bus2.stall_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit that generates the write-enable, flush and bubble strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Detects load-use hazards, kills wrong-path instructions on taken branches, freezes the pipe during multi-cycle data-memory accesses, and drains the pipe on HLT.
- Sits beside the ID stage and reads decoded fields from ID plus control bits already latched in ID/EX.

Parameters:
- REG_W, 4, register-specifier width.
- CNT_W, 16, width of the stall statistics counter.
- DRAIN_CYC, 3, cycles after HLT leaves ID before the pipe is considered empty.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  ID source register 1.
- id_rt  in  REG_W  ID source register 2.
- id_uses_rs  in  1  ID reads rs.
- id_uses_rt  in  1  ID reads rt.
- id_halt  in  1  ID instruction is HLT.
- ex_memread  in  1  ID/EX control: load in EX.
- ex_regwrite  in  1  ID/EX control: EX writes a register.
- ex_dst  in  REG_W  ID/EX dstReg.
- br_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_wen  out  1  PC write enable.
- ifid_wen  out  1  IF/ID writeReg.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_wen  out  1  ID/EX writeReg.
- idex_bubble  out  1  zero the ID/EX control bits [6:0] on load.
- exmem_wen  out  1  EX/MEM writeReg.
- memwb_wen  out  1  MEM/WB writeReg.
- halted  out  1  pipe drained after HLT; sticky until reset.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_wen=0.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALT. The state register, drain_cnt, halted and stall_cnt reset asynchronously on rst low to RUN, 0, 0 and 0.
- Outputs are combinational from the state and the inputs. With all inputs 0 in RUN: every wen=1, ifid_flush=0, idex_bubble=0.
- lu_haz = id_valid & ex_memread & ex_regwrite & (ex_dst!=0) & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
- memhold = mem_req & ~mem_ack.
- Per-cycle priority, highest first: memhold > br_taken > lu_haz > id_halt.
- memhold (any state except HALT):
  - All wen=0; flush and bubble=0.
  - From RUN or DRAIN, go to MEM_WAIT and remember the return state (1 flop). drain_cnt is frozen.
- MEM_WAIT:
  - Same outputs as memhold while ~mem_ack.
  - On mem_ack, outputs are as in the return state for that cycle, and the state returns to the return state.
  - mem_ack without mem_req is ignored.
- br_taken (RUN or DRAIN):
  - pc_wen=1, ifid_wen=1, ifid_flush=1, idex_wen=1, idex_bubble=1. Exactly two wrong-path instructions are killed.
  - In DRAIN, the branch cancels the drain: state becomes RUN and drain_cnt is cleared (the HLT was on the wrong path).
- lu_haz (RUN, no br_taken):
  - pc_wen=0, ifid_wen=0, idex_wen=1, idex_bubble=1. exmem_wen and memwb_wen stay 1.
  - Exactly one stall cycle results, because the bubble clears ex_memread.
- id_halt & id_valid (RUN, no higher event):
  - The HLT passes into ID/EX normally, pc_wen=0 and ifid_flush=1.
  - State goes to DRAIN with drain_cnt=DRAIN_CYC.
- DRAIN:
  - pc_wen=0, ifid_flush=1, other wens=1.
  - drain_cnt decrements once per non-held cycle. When it is 1 and decrements, go to HALT.
- HALT:
  - pc_wen=ifid_wen=idex_wen=exmem_wen=memwb_wen=0, halted=1.
  - All inputs are ignored. Only reset exits.
- stall_cnt: +1 every cycle where pc_wen=0 and state!=HALT, saturating at all-ones.
- Reset mid-operation (any state, including MEM_WAIT or DRAIN) returns immediately to RUN; no pending event survives.

Decomposition:
- Shared package pipe_pkg: state encoding (2-bit enum RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3), REG_W, and the ID/EX control-bit indices for memread/regwrite (bits within [6:0]).
- One natural sub-module, hz_detect: the purely combinational lu_haz comparator, reusable for a future forwarding unit.
- The FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
1. Load-use: ex_memread=1, ex_regwrite=1, ex_dst=3, id_rs=3, id_uses_rs=1, id_valid=1 for one cycle -> pc_wen=0, ifid_wen=0, idex_bubble=1 that cycle; stall_cnt 0->1; same with ex_dst=0 -> no stall.
2. Branch: br_taken=1 for one cycle while lu_haz is also true -> ifid_flush=1, idex_bubble=1, pc_wen=1; stall_cnt unchanged.
3. Memory wait: mem_req=1 with mem_ack=0 for 4 cycles, then mem_ack=1 -> all wen=0 for 4 cycles, all 1 on the ack cycle; stall_cnt +4.
4. Halt drain: id_halt=1, id_valid=1, then 3 quiet cycles -> DRAIN for 3 cycles with ifid_flush=1, then halted=1 and all wen=0; later br_taken and mem_req are ignored.
5. Cancelled halt: id_halt, then br_taken on the 2nd DRAIN cycle -> state RUN, halted stays 0, pc_wen=1 next cycle.
6. Reset: assert rst=0 during MEM_WAIT with stall_cnt=7 -> immediate RUN, stall_cnt=0, all wen=1 with idle inputs; saturation check with CNT_W=2 (stall 5 cycles -> stall_cnt=3).
